// File: rtl/alu_defs.sv
// Shared ALU definitions: logic-unit opcodes and the serial engine's FSM states.
package alu_defs;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_NAND  = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_PASS_A = 3'd6;
    localparam logic [2:0] OP_NOT_A  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational gate slice: applies the selected bitwise function to BITS_PER_CYCLE bits.
module logic_slice
    import alu_defs::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic [2:0]                op,
    input  logic [BITS_PER_CYCLE-1:0] a_bits,
    input  logic [BITS_PER_CYCLE-1:0] b_bits,
    output logic [BITS_PER_CYCLE-1:0] y_bits
);

    always_comb begin
        y_bits = '0;
        case (op)
            OP_AND:    y_bits = a_bits & b_bits;
            OP_NAND:   y_bits = ~(a_bits & b_bits);
            OP_OR:     y_bits = a_bits | b_bits;
            OP_NOR:    y_bits = ~(a_bits | b_bits);
            OP_XOR:    y_bits = a_bits ^ b_bits;
            OP_XNOR:   y_bits = ~(a_bits ^ b_bits);
            OP_PASS_A: y_bits = a_bits;
            OP_NOT_A:  y_bits = ~a_bits;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// Multi-cycle bitwise logic engine, BITS_PER_CYCLE bits per clock, valid/ready on both sides.
// Optional registered zero flag is enabled with `define SERIAL_LOGIC_ZERO_EN.
module serial_logic_unit
    import alu_defs::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
`ifdef SERIAL_LOGIC_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                    state, state_next;
    logic [WIDTH-1:0]          a_sr, b_sr, res_sr, res_next;
    logic [2:0]                op_r;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] y_bits;
    logic                      last_step;

    assign last_step = (cnt == LAST);

    logic_slice #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_slice (
        .op     (op_r),
        .a_bits (a_sr[BITS_PER_CYCLE-1:0]),
        .b_bits (b_sr[BITS_PER_CYCLE-1:0]),
        .y_bits (y_bits)
    );

    // New bits enter at the MSB so after N steps the result is in natural order.
    generate
        if (BITS_PER_CYCLE == WIDTH) begin : g_single
            assign res_next = y_bits;
        end else begin : g_multi
            assign res_next = {y_bits, res_sr[WIDTH-1:BITS_PER_CYCLE]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: if (last_step) state_next = ST_DONE;
            ST_DONE:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            op_r      <= OP_AND;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
`ifdef SERIAL_LOGIC_ZERO_EN
            zero      <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_sr   <= a;
                    b_sr   <= b;
                    op_r   <= op;
                    res_sr <= '0;
                    cnt    <= '0;
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> BITS_PER_CYCLE;
                    b_sr   <= b_sr >> BITS_PER_CYCLE;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last_step) begin
                        out       <= res_next;
                        out_valid <= 1'b1;
`ifdef SERIAL_LOGIC_ZERO_EN
                        zero      <= (res_next == '0);
`endif
                    end
                end
                ST_DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
